// File: rtl/i2c_target_responder.sv
// I2C target emulating a 16-bit sensor: ACKs TARGET_ADDR, serves tx_data on read,
// delivers write bytes on rx_data/rx_valid. Optional macro: GENERAL_CALL_EN.
// Ports: clk, reset_n (sync, active low), scl_in, sda_in, sda_oe (1 = pull SDA low),
//        tx_data[15:0], rx_data[7:0], rx_valid, busy, rd_done.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] tx_data,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // scl must be steadily high, so coincident scl/sda edges never flag START/STOP
  assign start    = scl_s & scl_d & ~sda_s & sda_d;
  assign stop     = scl_s & scl_d & sda_s & ~sda_d;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [6:0]  shreg, shreg_nx;
  logic        rw, rw_nx;
  logic        phase, phase_nx;
  logic [15:0] shadow, shadow_nx;
  logic        byte_sel, byte_sel_nx;
  logic        oe_nx, busy_nx, rx_valid_nx, rd_done_nx;
  logic [7:0]  rx_data_nx;

  logic [7:0] byte_in, cur_byte, next_byte;
  logic [2:0] next_idx;
  logic       hit;

  assign byte_in   = {shreg, sda_s};
  assign cur_byte  = byte_sel ? shadow[7:0] : shadow[15:8];
  assign next_byte = byte_sel ? shadow[15:8] : shadow[7:0];
  assign next_idx  = ~(cnt + 3'd1);

`ifdef GENERAL_CALL_EN
  assign hit = (byte_in[7:1] == TARGET_ADDR) ||
               (byte_in[7:1] == 7'h00 && !byte_in[0]);
`else
  assign hit = (byte_in[7:1] == TARGET_ADDR);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      phase    <= 1'b0;
      shadow   <= '0;
      byte_sel <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      shreg    <= shreg_nx;
      rw       <= rw_nx;
      phase    <= phase_nx;
      shadow   <= shadow_nx;
      byte_sel <= byte_sel_nx;
      sda_oe   <= oe_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      busy     <= busy_nx;
      rd_done  <= rd_done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shreg_nx    = shreg;
    rw_nx       = rw;
    phase_nx    = phase;
    shadow_nx   = shadow;
    byte_sel_nx = byte_sel;
    oe_nx       = sda_oe;
    rx_data_nx  = rx_data;
    busy_nx     = busy;
    rx_valid_nx = 1'b0;
    rd_done_nx  = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else if (start) begin
      state_nx = ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shreg_nx = byte_in[6:0];
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rw_nx    = byte_in[0];
            phase_nx = 1'b0;
            busy_nx  = hit;
            state_nx = hit ? ADDR_ACK : IGNORE;
          end
        end
        // phase 0: drive ACK on first fall; phase 1: end of ACK on next fall
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_nx    = 1'b1;
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
            cnt_nx   = '0;
            if (state == ADDR_ACK && rw) begin
              shadow_nx   = tx_data;
              byte_sel_nx = 1'b0;
              oe_nx       = ~tx_data[15];
              state_nx    = RD_BYTE;
            end else begin
              oe_nx    = 1'b0;
              state_nx = WR_BYTE;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg_nx = byte_in[6:0];
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_nx  = byte_in;
            rx_valid_nx = 1'b1;
            phase_nx    = 1'b0;
            state_nx    = WR_ACK;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (cnt == 3'd7) begin
            oe_nx    = 1'b0;
            state_nx = RD_ACK;
          end else begin
            cnt_nx = cnt + 3'd1;
            oe_nx  = ~cur_byte[next_idx];
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            rd_done_nx = 1'b1;
            busy_nx    = 1'b0;
            state_nx   = IGNORE;
          end else if (scl_fall) begin
            byte_sel_nx = ~byte_sel;
            cnt_nx      = '0;
            oe_nx       = ~next_byte[7];
            state_nx    = RD_BYTE;
          end
        end
        IDLE, IGNORE: ;
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-level master model driving a table of
// I2C steps, plus a hand-written reset-during-ACK sequence.
module tb_i2c_target_responder;

  localparam int Q = 200;
`ifdef GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  localparam int K_TX = 0, K_START = 1, K_STOP = 2, K_WR = 3, K_RD = 4;
  localparam int K_RXQ = 5, K_CNT = 6, K_MARK = 7, K_OEZ = 8, K_RXD = 9;

  typedef struct {
    int          kind;
    logic [15:0] dat;
    logic        ack;
    logic [7:0]  exp;
    int          bsy;
  } step_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_oe;
  logic [15:0] tx_data = 16'h0000;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, rd_done;
  logic        sda_line;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_responder dut (
    .clk(clk), .reset_n(reset_n),
    .scl_in(m_scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .rd_done(rd_done)
  );

  always #10 clk = ~clk;

  int total = 0, passed = 0;
  int rxv_cnt = 0, rdd_cnt = 0, oe_hits = 0, oe_mark = 0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxq.push_back(rx_data);
      rxv_cnt++;
    end
    if (rd_done) rdd_cnt++;
    if (sda_oe) oe_hits++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic wbit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    a = sda_line;
    m_scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      b = {b[6:0], sda_line};
      m_scl = 1'b0; #Q;
    end
    wbit(ack);
    m_sda = 1'b1;
  endtask

  function automatic step_t mk(int k, logic [15:0] d = 0, logic a = 0,
                               logic [7:0] e = 0, int b = -1);
    step_t s;
    s.kind = k; s.dat = d; s.ack = a; s.exp = e; s.bsy = b;
    return s;
  endfunction

  step_t tbl[$];

  initial begin
    logic a;
    logic [7:0] b;
    logic [7:0] got;

    // reset: all outputs low
    repeat (5) @(posedge clk);
    #1 chk("reset_outputs", {sda_oe, rx_data, rx_valid, busy, rd_done}, 0);
    @(negedge clk) reset_n = 1'b1;
    #Q;

    // reset asserted while the target is driving address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(b8(8'h90, i));
    m_sda = 1'b1;
    chk("ack_before_reset", sda_oe, 1'b1);
    chk("busy_before_reset", busy, 1'b1);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk) #1;
    chk("oe_release_on_reset", sda_oe, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("outputs_in_reset", {sda_oe, rx_data, rx_valid, busy, rd_done}, 0);
    @(negedge clk) reset_n = 1'b1;
    m_scl = 1'b1; #Q;
    #Q;

    // read 0x48: A5 then C3, master NACKs second
    tbl.push_back(mk(K_TX, 16'hA5C3));
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0091, 0, 8'h00, 1));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'hA5, 1));
    tbl.push_back(mk(K_RD, 0, 1'b1, 8'hC3, 0));
    tbl.push_back(mk(K_STOP));
    tbl.push_back(mk(K_CNT, {8'd1, 8'd0}));
    // write 0x12, 0x34
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0090, 0, 8'h00, 1));
    tbl.push_back(mk(K_WR, 16'h0012, 0, 8'h00, 1));
    tbl.push_back(mk(K_WR, 16'h0034, 0, 8'h00, 1));
    tbl.push_back(mk(K_STOP, 0, 0, 0, 0));
    tbl.push_back(mk(K_RXQ, 0, 0, 8'h12));
    tbl.push_back(mk(K_RXQ, 0, 0, 8'h34));
    tbl.push_back(mk(K_CNT, {8'd1, 8'd2}));
    // wrong address 0x4A read: never driven
    tbl.push_back(mk(K_MARK));
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0095, 0, 8'h01, 0));
    tbl.push_back(mk(K_STOP));
    tbl.push_back(mk(K_OEZ));
    tbl.push_back(mk(K_CNT, {8'd1, 8'd2}));
    // 4-byte read with tx_data change, then repeated START
    tbl.push_back(mk(K_TX, 16'hA5C3));
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0091, 0, 8'h00, 1));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'hA5));
    tbl.push_back(mk(K_TX, 16'h0000));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'hC3));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'hA5));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'hC3, 1));
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0091, 0, 8'h00, 1));
    tbl.push_back(mk(K_RD, 0, 1'b0, 8'h00));
    tbl.push_back(mk(K_RD, 0, 1'b1, 8'h00, 0));
    tbl.push_back(mk(K_STOP));
    tbl.push_back(mk(K_CNT, {8'd2, 8'd2}));
    // general call write
    tbl.push_back(mk(K_START));
    tbl.push_back(mk(K_WR, 16'h0000, 0, {7'd0, ~GC}));
    tbl.push_back(mk(K_WR, 16'h0055, 0, {7'd0, ~GC}));
    tbl.push_back(mk(K_STOP, 0, 0, 0, 0));
    tbl.push_back(mk(K_CNT, {8'd2, GC ? 8'd3 : 8'd2}));
    tbl.push_back(mk(K_RXD, 0, 0, GC ? 8'h55 : 8'h34));

    for (int i = 0; i < tbl.size(); i++) begin
      step_t s;
      s = tbl[i];
      case (s.kind)
        K_TX:    tx_data = s.dat;
        K_START: i2c_start();
        K_STOP:  i2c_stop();
        K_WR: begin
          send_byte(s.dat[7:0], a);
          chk($sformatf("step%0d wr%02h ack", i, s.dat[7:0]), a, s.exp[0]);
        end
        K_RD: begin
          recv_byte(b, s.ack);
          chk($sformatf("step%0d rd_byte", i), b, s.exp);
        end
        K_RXQ: begin
          got = 8'hxx;
          if (rxq.size() > 0) got = rxq.pop_front();
          chk($sformatf("step%0d rx_seq", i), got, s.exp);
        end
        K_CNT: begin
          chk($sformatf("step%0d rx_valid_cnt", i), rxv_cnt, s.dat[7:0]);
          chk($sformatf("step%0d rd_done_cnt", i), rdd_cnt, s.dat[15:8]);
        end
        K_MARK:  oe_mark = oe_hits;
        K_OEZ:   chk($sformatf("step%0d sda_oe_quiet", i), oe_hits, oe_mark);
        K_RXD:   chk($sformatf("step%0d rx_data", i), rx_data, s.exp);
        default: ;
      endcase
      if (s.bsy >= 0)
        chk($sformatf("step%0d busy", i), busy, s.bsy[0]);
    end

    #Q;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  function automatic logic b8(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
